img_stream_reader: RTL and testbench



---
 rtl/img_stream_reader_if.sv | 21 ++
 rtl/img_stream_reader.sv | 155 +++++++++++++++
 tb/tb_img_stream_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_stream_reader_if.sv
// Dmem read port plus valid/ready pixel stream with frame framing.
// The master side is the reader; the slave side is memory plus the pixel consumer.
interface img_stream_reader_if;
  logic        oDmem_rden;
  logic [6:0]  oDmem_addr;
  logic [15:0] iDmem_data [15:0];
  logic        oFVAL;
  logic        oDVAL;
  logic [15:0] oDATA;
  logic        iREADY;

  modport master (
    output oDmem_rden, oDmem_addr, oFVAL, oDVAL, oDATA,
    input  iDmem_data, iREADY
  );

  modport slave (
    input  oDmem_rden, oDmem_addr, oFVAL, oDVAL, oDATA,
    output iDmem_data, iREADY
  );
endinterface

// File: rtl/img_stream_reader.sv
// Replays a captured frame from Dmem (16 pixels per line) as a framed valid/ready pixel stream.
// Define IMG_READER_PREFETCH_EN to add a shadow line buffer that removes the inter-line bubble.
module img_stream_reader #(
  parameter int         NUM_PIXELS = 784,
  parameter logic [6:0] BASE_ADDR  = 7'd0,
  parameter int         RD_LAT     = 1
) (
  input  logic                pxlclk,
  input  logic                rst_n,
  input  logic                iEnable,
  input  logic                iStart,
  img_stream_reader_if.master bus,
  output logic                oBusy,
  output logic                oDone
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, STREAM, DONE} state_t;

  localparam logic [11:0] LAST_PIX = 12'(NUM_PIXELS - 1);
  localparam logic [1:0]  LAT      = 2'(RD_LAT);

  state_t      state;
  logic [15:0] linebuf [15:0];
  logic [3:0]  idx;
  logic [11:0] pix_cnt;
  logic [1:0]  lat_cnt;
  logic        xfer;
  logic        last_pix;
  logic        line_end;

`ifdef IMG_READER_PREFETCH_EN
  logic [15:0] shadow [15:0];
  logic        pf_busy;
  logic [1:0]  pf_cnt;
  logic        more_lines;

  // pix_cnt is 16*line when idx==0, so this asks whether another line follows the current one
  assign more_lines = ({1'b0, pix_cnt} + 13'd16) < 13'(NUM_PIXELS);
`endif

  assign xfer      = bus.oDVAL & bus.iREADY;
  assign last_pix  = (pix_cnt == LAST_PIX);
  assign line_end  = (idx == 4'd15) | last_pix;
  assign bus.oDATA = linebuf[idx];
  assign oBusy     = (state != IDLE);

  always_ff @(posedge pxlclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.oDmem_rden <= 1'b0;
      bus.oDmem_addr <= BASE_ADDR;
      bus.oFVAL      <= 1'b0;
      bus.oDVAL      <= 1'b0;
      oDone          <= 1'b0;
      idx            <= '0;
      pix_cnt        <= '0;
      lat_cnt        <= '0;
      for (int i = 0; i < 16; i++) linebuf[i] <= '0;
`ifdef IMG_READER_PREFETCH_EN
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
      pf_busy        <= 1'b0;
      pf_cnt         <= '0;
`endif
    end else begin
      bus.oDmem_rden <= 1'b0;
      oDone          <= 1'b0;
      // Abort wins over everything, including a transfer landing on the same edge
      if (state != IDLE && !iEnable) begin
        state     <= IDLE;
        bus.oFVAL <= 1'b0;
        bus.oDVAL <= 1'b0;
`ifdef IMG_READER_PREFETCH_EN
        pf_busy   <= 1'b0;
`endif
      end else begin
`ifdef IMG_READER_PREFETCH_EN
        // A prefetch is issued at idx 0 of a full line, so it lands long before idx 15
        if (pf_busy) begin
          if (pf_cnt == LAT) begin
            shadow  <= bus.iDmem_data;
            pf_busy <= 1'b0;
          end else begin
            pf_cnt <= pf_cnt + 2'd1;
          end
        end
`endif
        case (state)
          IDLE: begin
            if (iEnable && iStart) begin
              state          <= FETCH;
              bus.oDmem_rden <= 1'b1;
              bus.oDmem_addr <= BASE_ADDR;
              pix_cnt        <= '0;
              idx            <= '0;
              lat_cnt        <= '0;
            end
          end
          FETCH: begin
            state   <= WAIT_DATA;
            lat_cnt <= lat_cnt + 2'd1;
          end
          WAIT_DATA: begin
            if (lat_cnt == LAT) begin
              linebuf   <= bus.iDmem_data;
              idx       <= '0;
              state     <= STREAM;
              bus.oDVAL <= 1'b1;
              bus.oFVAL <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          STREAM: begin
            if (xfer) begin
              pix_cnt <= pix_cnt + 12'd1;
              idx     <= idx + 4'd1;
              if (last_pix) begin
                state     <= DONE;
                bus.oDVAL <= 1'b0;
                bus.oFVAL <= 1'b0;
                oDone     <= 1'b1;
              end else if (line_end) begin
`ifdef IMG_READER_PREFETCH_EN
                linebuf <= shadow;
                idx     <= '0;
`else
                state          <= FETCH;
                bus.oDmem_rden <= 1'b1;
                bus.oDmem_addr <= bus.oDmem_addr + 7'd1;
                bus.oDVAL      <= 1'b0;
                lat_cnt        <= '0;
`endif
              end
`ifdef IMG_READER_PREFETCH_EN
              else if (idx == 4'd0 && more_lines) begin
                bus.oDmem_rden <= 1'b1;
                bus.oDmem_addr <= bus.oDmem_addr + 7'd1;
                pf_busy        <= 1'b1;
                pf_cnt         <= '0;
              end
`endif
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_img_stream_reader.sv
// Directed bench for img_stream_reader: a default-parameter reader and a 20-pixel, base 5, latency 3 reader.
// Memory lines hold 16*addr+i; words read outside the latency window return a poison pattern.
`timescale 1ns/1ps
module tb_img_stream_reader;

  localparam int         NP0   = 784;
  localparam int         LAT0  = 1;
  localparam int         NP1   = 20;
  localparam logic [6:0] BASE1 = 7'd5;
  localparam int         LAT1  = 3;
`ifdef IMG_READER_PREFETCH_EN
  localparam int BUB0 = 0;
  localparam int BUB1 = 0;
`else
  localparam int BUB0 = 48 * (LAT0 + 1);
  localparam int BUB1 = LAT1 + 1;
`endif

  logic pxlclk = 1'b0;
  always #5 pxlclk = ~pxlclk;

  logic rst_n;
  logic en0, st0, rdy0, en1, st1, rdy1;
  logic busy0, done0, busy1, done1;

  img_stream_reader_if bus0 ();
  img_stream_reader_if bus1 ();

  img_stream_reader #(.NUM_PIXELS(NP0), .BASE_ADDR(7'd0), .RD_LAT(LAT0)) dut0 (
    .pxlclk(pxlclk), .rst_n(rst_n), .iEnable(en0), .iStart(st0),
    .bus(bus0.master), .oBusy(busy0), .oDone(done0)
  );

  img_stream_reader #(.NUM_PIXELS(NP1), .BASE_ADDR(BASE1), .RD_LAT(LAT1)) dut1 (
    .pxlclk(pxlclk), .rst_n(rst_n), .iEnable(en1), .iStart(st1),
    .bus(bus1.master), .oBusy(busy1), .oDone(done1)
  );

  assign bus0.iREADY = rdy0;
  assign bus1.iREADY = rdy1;

  // Memory models: data is only valid exactly LAT cycles after the read strobe
  logic       pv0 [LAT0];
  logic [6:0] pa0 [LAT0];
  logic       pv1 [LAT1];
  logic [6:0] pa1 [LAT1];

  always @(posedge pxlclk) begin
    for (int k = LAT0 - 1; k > 0; k--) begin
      pv0[k] <= pv0[k-1];
      pa0[k] <= pa0[k-1];
    end
    pv0[0] <= bus0.oDmem_rden;
    pa0[0] <= bus0.oDmem_addr;
    for (int k = LAT1 - 1; k > 0; k--) begin
      pv1[k] <= pv1[k-1];
      pa1[k] <= pa1[k-1];
    end
    pv1[0] <= bus1.oDmem_rden;
    pa1[0] <= bus1.oDmem_addr;
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bus0.iDmem_data[i] = pv0[LAT0-1] ? 16'(16 * pa0[LAT0-1] + i) : (16'hBAD0 | 16'(i));
      bus1.iDmem_data[i] = pv1[LAT1-1] ? 16'(16 * pa1[LAT1-1] + i) : (16'hBAD0 | 16'(i));
    end
  end

  logic        sel;
  logic        m_dval, m_fval, m_rdy, m_rden, m_done, m_busy;
  logic [15:0] m_data;
  logic [6:0]  m_addr;

  assign m_dval = sel ? bus1.oDVAL      : bus0.oDVAL;
  assign m_fval = sel ? bus1.oFVAL      : bus0.oFVAL;
  assign m_rdy  = sel ? rdy1            : rdy0;
  assign m_rden = sel ? bus1.oDmem_rden : bus0.oDmem_rden;
  assign m_done = sel ? done1           : done0;
  assign m_busy = sel ? busy1           : busy0;
  assign m_data = sel ? bus1.oDATA      : bus0.oDATA;
  assign m_addr = sel ? bus1.oDmem_addr : bus0.oDmem_addr;

  int errors = 0;
  int checks = 0;
  int cyc, xfers, order_errs, rdens, addr_errs, dones, bubbles, hold_errs;
  int first_dval, first_fval, first_rden, last_xfer, fval_fall, done_cyc;
  int pix_base, addr_base;
  logic        prev_stall, prev_fval;
  logic [15:0] prev_data;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic st, input logic rdy);
    if (sel) begin
      en1 = en; st1 = st; rdy1 = rdy;
    end else begin
      en0 = en; st0 = st; rdy0 = rdy;
    end
  endtask

  task automatic clearStats(input int pbase, input int abase);
    cyc = 0; xfers = 0; order_errs = 0; rdens = 0; addr_errs = 0; dones = 0;
    bubbles = 0; hold_errs = 0; first_dval = -1; first_fval = -1; first_rden = -1;
    last_xfer = -1; fval_fall = -1; done_cyc = -1;
    pix_base = pbase; addr_base = abase;
    prev_stall = 1'b0; prev_fval = 1'b0; prev_data = '0;
  endtask

  // Samples the selected reader mid-cycle, then returns just after the next active edge
  task automatic stepCycle();
    @(negedge pxlclk);
    if (prev_stall && (!m_dval || m_data != prev_data)) hold_errs++;
    if (m_dval && first_dval < 0) first_dval = cyc;
    if (m_fval && first_fval < 0) first_fval = cyc;
    if (prev_fval && !m_fval && fval_fall < 0) fval_fall = cyc;
    if (m_fval && !m_dval) bubbles++;
    if (m_rden) begin
      if (first_rden < 0) first_rden = cyc;
      if (m_addr != 7'(addr_base + rdens)) addr_errs++;
      rdens++;
    end
    if (m_done) begin
      dones++;
      done_cyc = cyc;
    end
    if (m_dval && m_rdy) begin
      if (m_data != 16'(pix_base + xfers)) order_errs++;
      xfers++;
      last_xfer = cyc;
    end
    prev_stall = m_dval && !m_rdy;
    prev_data  = m_data;
    prev_fval  = m_fval;
    cyc++;
    @(posedge pxlclk);
    #1;
  endtask

  task automatic startFrame(input logic rdy);
    applyStimulus(1'b1, 1'b1, rdy);
    stepCycle();
    applyStimulus(1'b1, 1'b0, rdy);
  endtask

  task automatic runFrame(input int maxc, input bit rnd, input int pulse_at);
    int n = 0;
    while (dones == 0 && n < maxc) begin
      applyStimulus(1'b1, n == pulse_at, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      stepCycle();
      n++;
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (3) stepCycle();
  endtask

  initial begin
    sel = 1'b0;
    en0 = 1'b0; st0 = 1'b0; rdy0 = 1'b1;
    en1 = 1'b0; st1 = 1'b0; rdy1 = 1'b1;
    rst_n = 1'b0;
    clearStats(0, 0);
    repeat (2) @(negedge pxlclk);
    checkOutput("rst_fval",  bus0.oFVAL, 0);
    checkOutput("rst_dval",  bus0.oDVAL, 0);
    checkOutput("rst_rden",  bus0.oDmem_rden, 0);
    checkOutput("rst_data",  bus0.oDATA, 0);
    checkOutput("rst_addr0", bus0.oDmem_addr, 0);
    checkOutput("rst_busy",  busy0, 0);
    checkOutput("rst_done",  done0, 0);
    checkOutput("rst_addr1", bus1.oDmem_addr, 5);
    @(posedge pxlclk);
    #1;
    rst_n = 1'b1;
    repeat (2) stepCycle();

    $display("[TB] start without enable");
    clearStats(0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (2) stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (5) stepCycle();
    checkOutput("noen_rden", rdens, 0);
    checkOutput("noen_busy", busy0, 0);

    $display("[TB] full frame, ready held high");
    clearStats(0, 0);
    startFrame(1'b1);
    runFrame(3000, 1'b0, -1);
    checkOutput("f1_xfers",      xfers, NP0);
    checkOutput("f1_order",      order_errs, 0);
    checkOutput("f1_rdens",      rdens, 49);
    checkOutput("f1_addr",       addr_errs, 0);
    checkOutput("f1_dones",      dones, 1);
    checkOutput("f1_bubbles",    bubbles, BUB0);
    checkOutput("f1_first_rden", first_rden, 1);
    checkOutput("f1_first_dval", first_dval, LAT0 + 2);
    checkOutput("f1_fval_rise",  first_fval, first_dval);
    checkOutput("f1_fval_fall",  fval_fall, last_xfer + 1);
    checkOutput("f1_done_cyc",   done_cyc, last_xfer + 1);
    checkOutput("f1_addr_hold",  bus0.oDmem_addr, 48);
    checkOutput("f1_idle",       busy0, 0);

    $display("[TB] full frame, random ready, start pulsed mid-frame");
    clearStats(0, 0);
    startFrame(1'b1);
    runFrame(6000, 1'b1, 300);
    checkOutput("f2_xfers", xfers, NP0);
    checkOutput("f2_order", order_errs, 0);
    checkOutput("f2_hold",  hold_errs, 0);
    checkOutput("f2_rdens", rdens, 49);
    checkOutput("f2_dones", dones, 1);

    $display("[TB] abort after 100 transfers");
    clearStats(0, 0);
    startFrame(1'b1);
    while (xfers < 100 && cyc < 1000) stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("ab_fval", bus0.oFVAL, 0);
    checkOutput("ab_dval", bus0.oDVAL, 0);
    checkOutput("ab_rden", bus0.oDmem_rden, 0);
    checkOutput("ab_busy", busy0, 0);
    repeat (10) stepCycle();
    checkOutput("ab_xfers", xfers, 100);
    checkOutput("ab_dones", dones, 0);

    clearStats(0, 0);
    startFrame(1'b1);
    runFrame(3000, 1'b0, -1);
    checkOutput("re_xfers", xfers, NP0);
    checkOutput("re_order", order_errs, 0);
    checkOutput("re_dones", dones, 1);

    $display("[TB] short frame at base 5, latency 3");
    sel = 1'b1;
    clearStats(16 * BASE1, BASE1);
    startFrame(1'b1);
    runFrame(500, 1'b0, -1);
    checkOutput("s_rdens",      rdens, 2);
    checkOutput("s_addr",       addr_errs, 0);
    checkOutput("s_xfers",      xfers, NP1);
    checkOutput("s_order",      order_errs, 0);
    checkOutput("s_first_rden", first_rden, 1);
    checkOutput("s_first_dval", first_dval, LAT1 + 2);
    checkOutput("s_bubbles",    bubbles, BUB1);
    checkOutput("s_fval_fall",  fval_fall, last_xfer + 1);
    checkOutput("s_dones",      dones, 1);
    checkOutput("s_idle",       m_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
